serial_paralelo: RTL and testbench

SERIAL_PARALELO -- requirements
Module: serial_paralelo

---
 rtl/serial_paralelo.sv | 143 ++++++++++++++
 tb/tb_serial_paralelo.sv | 217 +++++++++++++++++++++
 2 files changed

// File: rtl/serial_paralelo.sv
// Serial-to-parallel receiver: comma (8'hBC) alignment, four-comma lock, byte recovery.
// Optional loss-of-sync exit from ACTIVE is built when SP_LOS_DETECT_EN is defined.
module serial_paralelo (
    input  logic       clk8f,
    input  logic       reset,
    input  logic       serial_in,
    output logic [8:0] paralelo_out,
    output logic       word_strobe,
    output logic       active
);

    localparam logic [7:0] COM = 8'hBC;

    typedef enum logic [1:0] {
        HUNT   = 2'd0,
        COUNT  = 2'd1,
        ACTIVE = 2'd2
    } state_t;

    state_t      state_q, state_d;
    logic [7:0]  sr_q, sr_d;
    logic [2:0]  bit_cnt_q, bit_cnt_d;
    logic [2:0]  bc_cnt_q, bc_cnt_d;
    logic [8:0]  paralelo_out_q, paralelo_out_d;
    logic        word_strobe_q, word_strobe_d;
    logic        active_q, active_d;

    logic [7:0]  nb;
    logic        boundary;
    logic        is_com;
    logic        sr_msb_unused;

`ifdef SP_LOS_DETECT_EN
    logic [4:0]  los_cnt_q, los_cnt_d;
`endif

    // The oldest bit has already left the candidate byte by the time it reaches sr[7].
    assign sr_msb_unused = sr_q[7];

    assign nb       = {sr_q[6:0], serial_in};
    assign boundary = (bit_cnt_q == 3'd7);
    assign is_com   = (nb == COM);

    always_comb begin
        sr_d           = nb;
        state_d        = state_q;
        bit_cnt_d      = bit_cnt_q + 3'd1;
        bc_cnt_d       = bc_cnt_q;
        paralelo_out_d = 9'h000;
        word_strobe_d  = 1'b0;
        active_d       = 1'b0;
`ifdef SP_LOS_DETECT_EN
        los_cnt_d      = 5'd0;
`endif

        case (state_q)
            HUNT: begin
                // A comma match here defines the byte boundary for everything that follows.
                bit_cnt_d = 3'd0;
                bc_cnt_d  = 3'd0;
                if (is_com) begin
                    state_d  = COUNT;
                    bc_cnt_d = 3'd1;
                end
            end

            COUNT: begin
                if (boundary) begin
                    if (is_com) begin
                        bc_cnt_d = bc_cnt_q + 3'd1;
                        if (bc_cnt_q == 3'd3) begin
                            state_d  = ACTIVE;
                            active_d = 1'b1;
                        end
                    end else begin
                        state_d  = HUNT;
                        bc_cnt_d = 3'd0;
                    end
                end
            end

            ACTIVE: begin
                active_d       = 1'b1;
                paralelo_out_d = paralelo_out_q;
`ifdef SP_LOS_DETECT_EN
                los_cnt_d      = los_cnt_q;
`endif
                if (boundary) begin
                    paralelo_out_d = {~is_com, nb};
                    word_strobe_d  = 1'b1;
`ifdef SP_LOS_DETECT_EN
                    // The 32nd non-comma byte is still delivered; lock drops on the next edge.
                    if (is_com) begin
                        los_cnt_d = 5'd0;
                    end else if (los_cnt_q == 5'd31) begin
                        los_cnt_d = 5'd0;
                        state_d   = HUNT;
                    end else begin
                        los_cnt_d = los_cnt_q + 5'd1;
                    end
`endif
                end
            end

            default: begin
                state_d   = HUNT;
                bit_cnt_d = 3'd0;
                bc_cnt_d  = 3'd0;
            end
        endcase
    end

    always_ff @(posedge clk8f) begin
        if (reset) begin
            state_q        <= HUNT;
            sr_q           <= 8'h00;
            bit_cnt_q      <= 3'd0;
            bc_cnt_q       <= 3'd0;
            paralelo_out_q <= 9'h000;
            word_strobe_q  <= 1'b0;
            active_q       <= 1'b0;
`ifdef SP_LOS_DETECT_EN
            los_cnt_q      <= 5'd0;
`endif
        end else begin
            state_q        <= state_d;
            sr_q           <= sr_d;
            bit_cnt_q      <= bit_cnt_d;
            bc_cnt_q       <= bc_cnt_d;
            paralelo_out_q <= paralelo_out_d;
            word_strobe_q  <= word_strobe_d;
            active_q       <= active_d;
`ifdef SP_LOS_DETECT_EN
            los_cnt_q      <= los_cnt_d;
`endif
        end
    end

    assign paralelo_out = paralelo_out_q;
    assign word_strobe  = word_strobe_q;
    assign active       = active_q;

endmodule

// File: tb/tb_serial_paralelo.sv
// Directed bench for serial_paralelo: bit-history reference model checked every cycle,
// plus literal expectations at the key points of each scenario.
module tb_serial_paralelo;

    localparam logic [7:0] COM = 8'hBC;

    logic       clk8f = 1'b0;
    logic       reset = 1'b1;
    logic       serial_in = 1'b0;
    logic [8:0] paralelo_out;
    logic       word_strobe;
    logic       active;

    int n_checks = 0;
    int n_pass   = 0;

    serial_paralelo dut (
        .clk8f        (clk8f),
        .reset        (reset),
        .serial_in    (serial_in),
        .paralelo_out (paralelo_out),
        .word_strobe  (word_strobe),
        .active       (active)
    );

    always #5 clk8f = ~clk8f;

    // Reference model: every bit since reset is kept; alignment is a bit position.
    localparam int M_HUNT = 0, M_ALIGNING = 1, M_LOCKED = 2;
    bit         hist[$];
    int         m_mode = M_HUNT;
    int         m_anchor = 0;
    int         m_commas = 0;
    int         m_run = 0;
    int         m_n = 0;
    int         m_idx = 0;
    logic [7:0] m_win = 8'h00;
    bit         model_valid = 1'b0;
    logic [8:0] exp_pout = 9'h000;
    logic       exp_strobe = 1'b0;
    logic       exp_active = 1'b0;

    always @(posedge clk8f) begin
        if (reset) begin
            hist.delete();
            m_mode      = M_HUNT;
            m_commas    = 0;
            m_run       = 0;
            exp_pout    = 9'h000;
            exp_strobe  = 1'b0;
            exp_active  = 1'b0;
            model_valid = 1'b1;
        end else begin
            hist.push_back(serial_in);
            m_n = hist.size() - 1;
            for (int i = 0; i < 8; i++) begin
                m_idx = m_n - i;
                m_win[i] = (m_idx >= 0) ? hist[m_idx] : 1'b0;
            end
            exp_strobe = 1'b0;
            if (m_mode == M_HUNT) begin
                exp_pout   = 9'h000;
                exp_active = 1'b0;
                if (m_win == COM) begin
                    m_mode   = M_ALIGNING;
                    m_anchor = m_n;
                    m_commas = 1;
                end
            end else if (m_mode == M_ALIGNING) begin
                exp_pout   = 9'h000;
                exp_active = 1'b0;
                if ((m_n - m_anchor) % 8 == 0) begin
                    if (m_win == COM) begin
                        m_commas++;
                        if (m_commas == 4) begin
                            m_mode     = M_LOCKED;
                            m_run      = 0;
                            exp_active = 1'b1;
                        end
                    end else begin
                        m_mode = M_HUNT;
                    end
                end
            end else begin
                exp_active = 1'b1;
                if ((m_n - m_anchor) % 8 == 0) begin
                    exp_pout   = {m_win != COM, m_win};
                    exp_strobe = 1'b1;
                    if (m_win == COM) m_run = 0;
                    else m_run++;
`ifdef SP_LOS_DETECT_EN
                    if (m_run == 32) m_mode = M_HUNT;
`endif
                end
            end
        end
    end

    task automatic check(input string name, input logic [8:0] act, input logic [8:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
    endtask

    // Per-cycle comparison against the model.
    always @(negedge clk8f) begin
        if (model_valid) begin
            check("cyc_pout", paralelo_out, exp_pout);
            check("cyc_strobe", {8'h00, word_strobe}, {8'h00, exp_strobe});
            check("cyc_active", {8'h00, active}, {8'h00, exp_active});
        end
    end

    task automatic step(input logic r, input logic b);
        reset     = r;
        serial_in = b;
        @(posedge clk8f);
        @(negedge clk8f);
    endtask

    task automatic do_reset(input int cycles);
        for (int i = 0; i < cycles; i++) step(1'b1, 1'($urandom_range(0, 1)));
        $display("reset %0d cycles: paralelo_out=%h active=%b", cycles, paralelo_out, active);
    endtask

    task automatic send_byte(input logic [7:0] v);
        for (int i = 7; i >= 0; i--) step(1'b0, v[i]);
        $display("byte %h: paralelo_out=%h strobe=%b active=%b", v, paralelo_out, word_strobe, active);
    endtask

    task automatic lock4();
        for (int k = 0; k < 4; k++) send_byte(COM);
    endtask

    logic [7:0] b55 = 8'h55;

    initial begin
        // Lock
        do_reset(2);
        check("rst_pout", paralelo_out, 9'h000);
        check("rst_active", {8'h00, active}, 9'h000);
        check("rst_strobe", {8'h00, word_strobe}, 9'h000);
        for (int k = 0; k < 3; k++) send_byte(COM);
        for (int i = 7; i >= 1; i--) step(1'b0, COM[i]);
        check("lock_bit31_active", {8'h00, active}, 9'h000);
        step(1'b0, COM[0]);
        check("lock_bit32_active", {8'h00, active}, 9'h001);
        check("lock_bit32_pout", paralelo_out, 9'h000);
        check("model_lock", {8'h00, exp_active}, 9'h001);

        // Data
        send_byte(8'hFF);
        check("data_ff", paralelo_out, 9'h1FF);
        check("data_ff_strobe", {8'h00, word_strobe}, 9'h001);
        check("model_ff", exp_pout, 9'h1FF);
        step(1'b0, b55[7]);
        check("data_strobe_low", {8'h00, word_strobe}, 9'h000);
        check("data_ff_hold", paralelo_out, 9'h1FF);
        for (int i = 6; i >= 0; i--) step(1'b0, b55[i]);
        check("data_55", paralelo_out, 9'h155);
        send_byte(8'h00);
        check("data_00", paralelo_out, 9'h100);
        send_byte(COM);
        check("data_com", paralelo_out, 9'h0BC);
        check("data_com_active", {8'h00, active}, 9'h001);

        // Broken preamble
        do_reset(2);
        for (int k = 0; k < 3; k++) send_byte(COM);
        send_byte(8'h55);
        check("broken_active", {8'h00, active}, 9'h000);
        check("broken_pout", paralelo_out, 9'h000);
        lock4();
        check("broken_relock", {8'h00, active}, 9'h001);

        // Offset
        do_reset(2);
        for (int i = 0; i < 3; i++) step(1'b0, 1'($urandom_range(0, 1)));
        lock4();
        check("offset_lock", {8'h00, active}, 9'h001);
        send_byte(8'hA5);
        check("offset_a5", paralelo_out, 9'h1A5);
        check("offset_a5_strobe", {8'h00, word_strobe}, 9'h001);

        // Reset mid-byte in ACTIVE
        for (int i = 7; i >= 4; i--) step(1'b0, b55[i]);
        step(1'b1, 1'($urandom_range(0, 1)));
        $display("mid-byte reset: paralelo_out=%h active=%b", paralelo_out, active);
        check("midrst_pout", paralelo_out, 9'h000);
        check("midrst_active", {8'h00, active}, 9'h000);
        check("midrst_strobe", {8'h00, word_strobe}, 9'h000);
        for (int k = 0; k < 3; k++) send_byte(COM);
        check("midrst_3com", {8'h00, active}, 9'h000);
        send_byte(COM);
        check("midrst_relock", {8'h00, active}, 9'h001);

        // Long run of non-comma bytes
        for (int k = 0; k < 31; k++) send_byte(8'h00);
        check("los_31", {8'h00, active}, 9'h001);
        send_byte(8'h00);
        check("los_32_pout", paralelo_out, 9'h100);
        check("los_32_active", {8'h00, active}, 9'h001);
        step(1'b0, 1'b0);
`ifdef SP_LOS_DETECT_EN
        check("los_drop_active", {8'h00, active}, 9'h000);
        check("los_drop_pout", paralelo_out, 9'h000);
`else
        check("los_hold_active", {8'h00, active}, 9'h001);
        check("los_hold_pout", paralelo_out, 9'h100);
`endif
        step(1'b0, 1'b0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
